// File: rtl/lcd_i2c_pkg.sv
// Shared definitions for the PCF8574 LCD backpack I2C transmitter.
// Contents: FSM state enum, PCF8574 expander bit positions, default slave
// address, and a helper that packs one expander byte.
package lcd_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP
    } state_t;

    // PCF8574 expander pin mapping on the common LCD backpack
    localparam int unsigned PCF_RS = 0;
    localparam int unsigned PCF_RW = 1;
    localparam int unsigned PCF_EN = 2;
    localparam int unsigned PCF_BL = 3;

    localparam logic [6:0] DEFAULT_I2C_ADDR = 7'h27;

    // Expander byte: nibble on P7..P4, control lines on P3..P0; RW is always write.
    function automatic logic [7:0] pcf_byte(input logic [3:0] nibble,
                                            input logic       bl,
                                            input logic       en,
                                            input logic       rs);
        logic [7:0] b;
        b         = '0;
        b[7:4]    = nibble;
        b[PCF_BL] = bl;
        b[PCF_EN] = en;
        b[PCF_RW] = 1'b0;
        b[PCF_RS] = rs;
        return b;
    endfunction

endpackage

// File: rtl/lcd_i2c_tx_if.sv
// Request handshake between an LCD command source and lcd_i2c_tx.
//   in_valid : request to send one LCD byte
//   in_ready : transmitter can accept a request this cycle
//   in_rs    : LCD register select (0 = command, 1 = data)
//   in_data  : LCD byte
// master = request source, slave = lcd_i2c_tx.
interface lcd_i2c_tx_if;
    logic       in_valid;
    logic       in_ready;
    logic       in_rs;
    logic [7:0] in_data;

    modport master (output in_valid, output in_rs, output in_data, input in_ready);
    modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/i2c_qtick.sv
// Quarter-period strobe generator for the I2C bit engine.
//   clk, reset : system clock, async active-high reset
//   clear      : hold the divider at zero (asserted while the engine is idle)
//   tick       : one-cycle strobe at the end of every CLK_DIV-cycle quarter
module i2c_qtick #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = !clear && (cnt == LAST);
endmodule

// File: rtl/lcd_i2c_tx.sv
// HD44780 LCD byte transmitter over I2C to a PCF8574 backpack (4-bit mode).
// Each accepted byte becomes one I2C write: START, address {I2C_ADDR,0},
// four expander bytes (high nibble EN=1/EN=0, low nibble EN=1/EN=0), STOP.
//   clk, reset : system clock, async active-high reset
//   lcd        : request handshake (lcd_i2c_tx_if.slave)
//   busy       : transaction in progress
//   ack_err    : sticky NACK flag
//   scl        : I2C clock, push-pull
//   sda        : I2C data, open-drain (0 or released)
// Build option: define LCD_I2C_TX_ACK_CHECK_EN to sample the slave ACK,
// flag NACKs on ack_err and abort straight to STOP. Undefined: ACK ignored,
// ack_err tied low, all five bytes always sent.
module lcd_i2c_tx
    import lcd_i2c_pkg::*;
#(
    parameter logic [6:0]  I2C_ADDR  = DEFAULT_I2C_ADDR,
    parameter int unsigned CLK_DIV   = 125,
    parameter logic        BACKLIGHT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    lcd_i2c_tx_if.slave lcd,
    output logic        busy,
    output logic        ack_err,
    output logic        scl,
    inout  wire         sda
);
    state_t     state, state_n;
    logic [1:0] q;          // quarter index within START/bit/ACK/STOP
    logic [2:0] bit_cnt;
    logic [2:0] byte_cnt;   // 0 = address, 1..4 = payload
    logic [7:0] sh;
    logic       rs_q;
    logic [7:0] data_q;
    logic       tick;
    logic       accept;
    logic       abort;
    logic       sda_low;
    logic [2:0] nxt_idx;
    logic [7:0] nxt_byte;

    i2c_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
        .clk   (clk),
        .reset (reset),
        .clear (state == ST_IDLE),
        .tick  (tick)
    );

    assign lcd.in_ready = (state == ST_IDLE);
    assign accept       = lcd.in_valid && lcd.in_ready;

`ifdef LCD_I2C_TX_ACK_CHECK_EN
    logic nack_q;
    logic ack_err_q;

    // Sampled as SCL rises into the third quarter of the ACK slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nack_q    <= 1'b0;
            ack_err_q <= 1'b0;
        end else if (state == ST_ACK && tick && q == 2'd1) begin
            nack_q <= sda;
            if (sda) begin
                ack_err_q <= 1'b1;
            end
        end
    end

    assign abort   = nack_q;
    assign ack_err = ack_err_q;
`else
    assign abort   = 1'b0;
    assign ack_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = (state != ST_IDLE);
        scl     = 1'b1;
        sda_low = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) state_n = ST_START;
            end
            ST_START: begin
                sda_low = 1'b1;
                if (tick && q == 2'd1) state_n = ST_BIT;
            end
            ST_BIT: begin
                scl     = q[1];
                sda_low = !sh[7];
                if (tick && q == 2'd3 && bit_cnt == 3'd7) state_n = ST_ACK;
            end
            ST_ACK: begin
                scl = q[1];
                if (tick && q == 2'd3) begin
                    state_n = (abort || byte_cnt == 3'd4) ? ST_STOP : ST_BIT;
                end
            end
            ST_STOP: begin
                // SCL low then high with SDA held low; SDA releases on IDLE entry.
                scl     = q[0];
                sda_low = 1'b1;
                if (tick && q == 2'd1) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        nxt_idx  = byte_cnt + 3'd1;
        nxt_byte = pcf_byte((nxt_idx <= 3'd2) ? data_q[7:4] : data_q[3:0],
                            BACKLIGHT, nxt_idx[0], rs_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q        <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            sh       <= '0;
            rs_q     <= 1'b0;
            data_q   <= '0;
        end else if (accept) begin
            q        <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            sh       <= {I2C_ADDR, 1'b0};
            rs_q     <= lcd.in_rs;
            data_q   <= lcd.in_data;
        end else if (tick) begin
            // Any state change restarts the quarter count; a bit slot wraps on its own.
            q <= (state_n != state) ? 2'd0 : q + 2'd1;
            if (state == ST_BIT && q == 2'd3) begin
                if (bit_cnt == 3'd7) begin
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                    sh      <= {sh[6:0], 1'b0};
                end
            end
            if (state == ST_ACK && state_n == ST_BIT) begin
                byte_cnt <= nxt_idx;
                sh       <= nxt_byte;
            end
        end
    end

    assign sda = sda_low ? 1'b0 : 1'bz;
endmodule
